// File: rtl/core_pkg.sv
// Shared pipeline-control definitions: forwarding-source encodings, hazard FSM states
// and the register-match predicate used by the hazard controller.
package core_pkg;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_EX  = 2'd1;
  localparam logic [1:0] FWD_MEM = 2'd2;
  localparam logic [1:0] FWD_WB  = 2'd3;

  typedef enum logic {
    RUN      = 1'b0,
    LU_STALL = 1'b1
  } hz_state_e;

  // x0 is hardwired to zero, so it never creates a dependency.
  function automatic logic reg_match(
    input logic       have_inst,
    input logic       rf_we,
    input logic [4:0] w_r,
    input logic [4:0] r_r,
    input logic       r_en,
    input logic       id_have
  );
    return have_inst && rf_we && (w_r == r_r) && (r_r != 5'd0) && r_en && id_have;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous active-low reset and synchronous clear.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] r_cnt;

  // clear beats increment; holding at all-ones prevents wrap
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign cnt = r_cnt;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage RV32 pipeline: load-use / RAW stalls, branch flushes,
// operand-forwarding selects and saturating performance counters.
module hazard_ctrl
  import core_pkg::*;
#(
  parameter int CNT_W  = 32,
  parameter int FWD_EN = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_have_inst,
  input  logic [4:0]       id_rR1,
  input  logic [4:0]       id_rR2,
  input  logic             id_re1,
  input  logic             id_re2,
  input  logic             ex_have_inst,
  input  logic [4:0]       ex_wR,
  input  logic             ex_rf_we,
  input  logic             ex_is_load,
  input  logic             ex_branch_taken,
  input  logic             mem_have_inst,
  input  logic [4:0]       mem_wR,
  input  logic             mem_rf_we,
  input  logic             wb_have_inst,
  input  logic [4:0]       wb_wR,
  input  logic             wb_rf_we,
  input  logic             cnt_clr,
  output logic             pipeline_stop,
  output logic             id_ex_hazard,
  output logic             if_id_flush,
  output logic [1:0]       fwd_sel1,
  output logic [1:0]       fwd_sel2,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] fwd_cnt
);

  hz_state_e r_state;
  hz_state_e w_state_nxt;

  logic w_ex_m1, w_ex_m2, w_mem_m1, w_mem_m2, w_wb_m1, w_wb_m2;
  logic w_lu_stall, w_raw_stall, w_stall;
  logic w_stall_inc, w_flush_inc, w_fwd_inc;
  logic [1:0] w_sel1, w_sel2;

  assign w_ex_m1  = reg_match(ex_have_inst,  ex_rf_we,  ex_wR,  id_rR1, id_re1, id_have_inst);
  assign w_ex_m2  = reg_match(ex_have_inst,  ex_rf_we,  ex_wR,  id_rR2, id_re2, id_have_inst);
  assign w_mem_m1 = reg_match(mem_have_inst, mem_rf_we, mem_wR, id_rR1, id_re1, id_have_inst);
  assign w_mem_m2 = reg_match(mem_have_inst, mem_rf_we, mem_wR, id_rR2, id_re2, id_have_inst);
  assign w_wb_m1  = reg_match(wb_have_inst,  wb_rf_we,  wb_wR,  id_rR1, id_re1, id_have_inst);
  assign w_wb_m2  = reg_match(wb_have_inst,  wb_rf_we,  wb_wR,  id_rR2, id_re2, id_have_inst);

  // Without forwarding only the WB write-through path remains.
  function automatic logic [1:0] fwd_pick(input logic ex_m, input logic mem_m, input logic wb_m);
    logic [1:0] sel;
    sel = FWD_RF;
    if (FWD_EN != 0) begin
      if (ex_m && !ex_is_load) sel = FWD_EX;
      else if (mem_m)          sel = FWD_MEM;
      else if (wb_m)           sel = FWD_WB;
      else                     sel = FWD_RF;
    end else begin
      if (wb_m) sel = FWD_WB;
      else      sel = FWD_RF;
    end
    return sel;
  endfunction

  assign w_sel1 = fwd_pick(w_ex_m1, w_mem_m1, w_wb_m1);
  assign w_sel2 = fwd_pick(w_ex_m2, w_mem_m2, w_wb_m2);

  assign w_lu_stall  = (FWD_EN != 0) && (r_state == RUN) && ex_is_load && (w_ex_m1 || w_ex_m2);
  assign w_raw_stall = (FWD_EN == 0) && (w_ex_m1 || w_ex_m2 || w_mem_m1 || w_mem_m2);
  assign w_stall     = w_lu_stall || w_raw_stall;

  // stall FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= RUN;
    else        r_state <= w_state_nxt;
  end

  // next state: a load-use bubble lasts exactly one cycle; a flush keeps RUN
  always_comb begin
    w_state_nxt = RUN;
    case (r_state)
      RUN: begin
        if (w_lu_stall && !ex_branch_taken) w_state_nxt = LU_STALL;
        else                                w_state_nxt = RUN;
      end
      LU_STALL: w_state_nxt = RUN;
      default:  w_state_nxt = RUN;
    endcase
  end

  // control outputs: reset forcing, then flush, then stall
  always_comb begin
    pipeline_stop = 1'b0;
    id_ex_hazard  = 1'b0;
    if_id_flush   = 1'b0;
    fwd_sel1      = FWD_RF;
    fwd_sel2      = FWD_RF;
    if (!rst_n) begin
      id_ex_hazard = 1'b1;
      if_id_flush  = 1'b1;
    end else begin
      fwd_sel1 = w_sel1;
      fwd_sel2 = w_sel2;
      if (ex_branch_taken) begin
        if_id_flush  = 1'b1;
        id_ex_hazard = 1'b1;
      end else if (w_stall) begin
        pipeline_stop = 1'b1;
        id_ex_hazard  = 1'b1;
      end else begin
        pipeline_stop = 1'b0;
      end
    end
  end

  assign w_stall_inc = w_stall && !ex_branch_taken;
  assign w_flush_inc = ex_branch_taken;
  assign w_fwd_inc   = ((w_sel1 != FWD_RF) || (w_sel2 != FWD_RF)) && !w_stall && !ex_branch_taken;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk(clk), .rst_n(rst_n), .clr(cnt_clr), .inc(w_stall_inc), .cnt(stall_cnt)
  );
  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk(clk), .rst_n(rst_n), .clr(cnt_clr), .inc(w_flush_inc), .cnt(flush_cnt)
  );
  sat_counter #(.CNT_W(CNT_W)) u_fwd_cnt (
    .clk(clk), .rst_n(rst_n), .clr(cnt_clr), .inc(w_fwd_inc), .cnt(fwd_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: one forwarding and one non-forwarding instance share
// stimulus; directed vectors push hand-computed expectations, a negedge monitor checks them.
module tb_hazard_ctrl;

  typedef struct packed {
    logic       stop;
    logic       haz;
    logic       flush;
    logic [1:0] s1;
    logic [1:0] s2;
  } out_t;

  typedef struct packed {
    logic [3:0] sc;
    logic [3:0] fc;
    logic [3:0] wc;
  } cnt_t;

  typedef struct {
    string nm;
    bit    oc;
    out_t  o0;
    out_t  o1;
    bit    cc;
    cnt_t  c0;
    cnt_t  c1;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic id_have_inst, id_re1, id_re2;
  logic [4:0] id_rR1, id_rR2, ex_wR, mem_wR, wb_wR;
  logic ex_have_inst, ex_rf_we, ex_is_load, ex_branch_taken;
  logic mem_have_inst, mem_rf_we, wb_have_inst, wb_rf_we, cnt_clr;

  logic stop0, haz0, flush0, stop1, haz1, flush1;
  logic [1:0] sel1_0, sel2_0, sel1_1, sel2_1;
  logic [3:0] sc0, fc0, wc0, sc1, fc1, wc1;

  exp_t q[$];
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.CNT_W(4), .FWD_EN(1)) u_fwd (
    .clk(clk), .rst_n(rst_n), .id_have_inst(id_have_inst), .id_rR1(id_rR1), .id_rR2(id_rR2),
    .id_re1(id_re1), .id_re2(id_re2), .ex_have_inst(ex_have_inst), .ex_wR(ex_wR),
    .ex_rf_we(ex_rf_we), .ex_is_load(ex_is_load), .ex_branch_taken(ex_branch_taken),
    .mem_have_inst(mem_have_inst), .mem_wR(mem_wR), .mem_rf_we(mem_rf_we),
    .wb_have_inst(wb_have_inst), .wb_wR(wb_wR), .wb_rf_we(wb_rf_we), .cnt_clr(cnt_clr),
    .pipeline_stop(stop0), .id_ex_hazard(haz0), .if_id_flush(flush0),
    .fwd_sel1(sel1_0), .fwd_sel2(sel2_0), .stall_cnt(sc0), .flush_cnt(fc0), .fwd_cnt(wc0)
  );

  hazard_ctrl #(.CNT_W(4), .FWD_EN(0)) u_nofwd (
    .clk(clk), .rst_n(rst_n), .id_have_inst(id_have_inst), .id_rR1(id_rR1), .id_rR2(id_rR2),
    .id_re1(id_re1), .id_re2(id_re2), .ex_have_inst(ex_have_inst), .ex_wR(ex_wR),
    .ex_rf_we(ex_rf_we), .ex_is_load(ex_is_load), .ex_branch_taken(ex_branch_taken),
    .mem_have_inst(mem_have_inst), .mem_wR(mem_wR), .mem_rf_we(mem_rf_we),
    .wb_have_inst(wb_have_inst), .wb_wR(wb_wR), .wb_rf_we(wb_rf_we), .cnt_clr(cnt_clr),
    .pipeline_stop(stop1), .id_ex_hazard(haz1), .if_id_flush(flush1),
    .fwd_sel1(sel1_1), .fwd_sel2(sel2_1), .stall_cnt(sc1), .flush_cnt(fc1), .fwd_cnt(wc1)
  );

  function automatic out_t mk_out(input logic st, input logic hz, input logic fl,
                                  input logic [1:0] a, input logic [1:0] b);
    return {st, hz, fl, a, b};
  endfunction

  function automatic cnt_t mk_cnt(input logic [3:0] s, input logic [3:0] f, input logic [3:0] w);
    return {s, f, w};
  endfunction

  task automatic chk(input string nm, input string what, input logic [11:0] act, input logic [11:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s/%s: got %h, expected %h", nm, what, act, req);
    end
  endtask

  // monitor: one expectation per cycle, checked mid-cycle
  always @(negedge clk) begin : monitor
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      if (e.oc) begin
        chk(e.nm, "out_fwd",   12'({stop0, haz0, flush0, sel1_0, sel2_0}), 12'(e.o0));
        chk(e.nm, "out_nofwd", 12'({stop1, haz1, flush1, sel1_1, sel2_1}), 12'(e.o1));
      end
      if (e.cc) begin
        chk(e.nm, "cnt_fwd",   {sc0, fc0, wc0}, e.c0);
        chk(e.nm, "cnt_nofwd", {sc1, fc1, wc1}, e.c1);
      end
    end
  end

  task automatic push(input string nm, input out_t o0, input out_t o1,
                      input bit cc, input cnt_t c0, input cnt_t c1);
    exp_t e;
    e.nm = nm; e.oc = 1'b1; e.o0 = o0; e.o1 = o1; e.cc = cc; e.c0 = c0; e.c1 = c1;
    q.push_back(e);
  endtask

  task automatic idle_in();
    id_have_inst = 1'b0; id_rR1 = 5'd0; id_rR2 = 5'd0; id_re1 = 1'b0; id_re2 = 1'b0;
    ex_have_inst = 1'b0; ex_wR = 5'd0; ex_rf_we = 1'b0; ex_is_load = 1'b0; ex_branch_taken = 1'b0;
    mem_have_inst = 1'b0; mem_wR = 5'd0; mem_rf_we = 1'b0;
    wb_have_inst = 1'b0; wb_wR = 5'd0; wb_rf_we = 1'b0; cnt_clr = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle_in();
  endtask

  task automatic ex_w(input logic [4:0] r, input logic ld);
    ex_have_inst = 1'b1; ex_wR = r; ex_rf_we = 1'b1; ex_is_load = ld;
  endtask
  task automatic mem_w(input logic [4:0] r);
    mem_have_inst = 1'b1; mem_wR = r; mem_rf_we = 1'b1;
  endtask
  task automatic wb_w(input logic [4:0] r);
    wb_have_inst = 1'b1; wb_wR = r; wb_rf_we = 1'b1;
  endtask
  task automatic id_r1(input logic [4:0] r);
    id_have_inst = 1'b1; id_rR1 = r; id_re1 = 1'b1;
  endtask
  task automatic id_r2(input logic [4:0] r);
    id_have_inst = 1'b1; id_rR2 = r; id_re2 = 1'b1;
  endtask

  initial begin
    idle_in();
    // reset forces outputs even with a live forwarding match
    tick(); rst_n = 1'b0; ex_w(5'd5, 1'b0); id_r1(5'd5);
    push("reset", mk_out(0,1,1,0,0), mk_out(0,1,1,0,0), 1, mk_cnt(0,0,0), mk_cnt(0,0,0));
    tick(); rst_n = 1'b1; ex_w(5'd5, 1'b0); id_r1(5'd5);
    push("fwd_ex", mk_out(0,0,0,1,0), mk_out(1,1,0,0,0), 1, mk_cnt(0,0,0), mk_cnt(0,0,0));
    tick(); mem_w(5'd5); id_r1(5'd5);
    push("fwd_mem", mk_out(0,0,0,2,0), mk_out(1,1,0,0,0), 1, mk_cnt(0,0,1), mk_cnt(1,0,0));
    tick(); wb_w(5'd5); id_r1(5'd5);
    push("fwd_wb", mk_out(0,0,0,3,0), mk_out(0,0,0,3,0), 1, mk_cnt(0,0,2), mk_cnt(2,0,0));
    tick(); ex_w(5'd5, 1'b0); mem_w(5'd5); id_r1(5'd5);
    push("fwd_ex_over_mem", mk_out(0,0,0,1,0), mk_out(1,1,0,0,0), 1, mk_cnt(0,0,3), mk_cnt(2,0,1));
    tick(); ex_w(5'd0, 1'b0); id_r1(5'd0);
    push("x0_no_match", mk_out(0,0,0,0,0), mk_out(0,0,0,0,0), 1, mk_cnt(0,0,4), mk_cnt(3,0,1));
    tick(); ex_w(5'd5, 1'b0); ex_have_inst = 1'b0; id_r1(5'd5);
    push("ex_invalid", mk_out(0,0,0,0,0), mk_out(0,0,0,0,0), 1, mk_cnt(0,0,4), mk_cnt(3,0,1));
    tick(); ex_w(5'd5, 1'b0); id_r1(5'd5); id_have_inst = 1'b0; cnt_clr = 1'b1;
    push("id_invalid", mk_out(0,0,0,0,0), mk_out(0,0,0,0,0), 1, mk_cnt(0,0,4), mk_cnt(3,0,1));
    // load-use on rR2
    tick(); ex_w(5'd6, 1'b1); id_r2(5'd6);
    push("lu_stall", mk_out(1,1,0,0,0), mk_out(1,1,0,0,0), 1, mk_cnt(0,0,0), mk_cnt(0,0,0));
    tick(); ex_w(5'd6, 1'b1); mem_w(5'd6); id_r2(5'd6);
    push("lu_masked_fwd_mem", mk_out(0,0,0,0,2), mk_out(1,1,0,0,0), 1, mk_cnt(1,0,0), mk_cnt(1,0,0));
    tick(); ex_w(5'd6, 1'b1); id_r2(5'd6);
    push("lu_back_to_back", mk_out(1,1,0,0,0), mk_out(1,1,0,0,0), 1, mk_cnt(1,0,1), mk_cnt(2,0,0));
    tick();
    push("idle", mk_out(0,0,0,0,0), mk_out(0,0,0,0,0), 1, mk_cnt(2,0,1), mk_cnt(3,0,0));
    // a flush overrides the stall and keeps the FSM in RUN
    tick(); ex_w(5'd6, 1'b1); id_r2(5'd6); ex_branch_taken = 1'b1;
    push("branch_beats_stall", mk_out(0,1,1,0,0), mk_out(0,1,1,0,0), 1, mk_cnt(2,0,1), mk_cnt(3,0,0));
    tick(); ex_w(5'd6, 1'b1); id_r2(5'd6);
    push("after_branch_run", mk_out(1,1,0,0,0), mk_out(1,1,0,0,0), 1, mk_cnt(2,1,1), mk_cnt(3,1,0));
    // reset while in LU_STALL
    tick(); rst_n = 1'b0; ex_w(5'd6, 1'b1); id_r2(5'd6);
    push("reset_in_lu", mk_out(0,1,1,0,0), mk_out(0,1,1,0,0), 1, mk_cnt(3,1,1), mk_cnt(4,1,0));
    tick(); rst_n = 1'b1; ex_w(5'd6, 1'b1); id_r2(5'd6);
    push("post_reset_run", mk_out(1,1,0,0,0), mk_out(1,1,0,0,0), 1, mk_cnt(0,0,0), mk_cnt(0,0,0));
    // no-forwarding RAW: stall with producer in EX, then MEM, write-through from WB
    tick(); ex_w(5'd7, 1'b0); id_r1(5'd7);
    push("raw_ex", mk_out(0,0,0,1,0), mk_out(1,1,0,0,0), 1, mk_cnt(1,0,0), mk_cnt(1,0,0));
    tick(); mem_w(5'd7); id_r1(5'd7);
    push("raw_mem", mk_out(0,0,0,2,0), mk_out(1,1,0,0,0), 1, mk_cnt(1,0,1), mk_cnt(2,0,0));
    tick(); wb_w(5'd7); id_r1(5'd7);
    push("raw_wb", mk_out(0,0,0,3,0), mk_out(0,0,0,3,0), 1, mk_cnt(1,0,2), mk_cnt(3,0,0));
    // saturation: stall every cycle on the non-forwarding instance
    for (int i = 0; i < 15; i++) begin
      tick(); ex_w(5'd7, 1'b0); id_r1(5'd7);
      push("sat_loop", mk_out(0,0,0,1,0), mk_out(1,1,0,0,0), (i == 0),
           mk_cnt(1,0,3), mk_cnt(3,0,1));
    end
    tick(); ex_w(5'd7, 1'b0); id_r1(5'd7);
    push("saturated", mk_out(0,0,0,1,0), mk_out(1,1,0,0,0), 1, mk_cnt(1,0,15), mk_cnt(15,0,1));
    tick(); ex_w(5'd7, 1'b0); id_r1(5'd7); cnt_clr = 1'b1;
    push("no_wrap", mk_out(0,0,0,1,0), mk_out(1,1,0,0,0), 1, mk_cnt(1,0,15), mk_cnt(15,0,1));
    tick(); ex_w(5'd7, 1'b0); id_r1(5'd7);
    push("cleared", mk_out(0,0,0,1,0), mk_out(1,1,0,0,0), 1, mk_cnt(0,0,0), mk_cnt(0,0,0));
    tick();
    push("count_after_clr", mk_out(0,0,0,0,0), mk_out(0,0,0,0,0), 1, mk_cnt(0,0,1), mk_cnt(1,0,0));

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage RV32 core.
- Drives the pipeline_stop and id_ex_hazard controls consumed by the ID/EX register, plus the IF/ID flush and operand-forwarding selects.
- Detects load-use stalls, taken-branch/jump flushes and RAW forwarding paths.
- Keeps a small stall FSM and saturating performance counters.

Parameters:
CNT_W, 32, width of each performance counter
FWD_EN, 1, 1 = forwarding enabled; 0 = every RAW hazard stalls until WB has written back

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
id_have_inst  input  1  valid instruction in ID
id_rR1  input  5  ID source register 1
id_rR2  input  5  ID source register 2
id_re1  input  1  ID reads rR1
id_re2  input  1  ID reads rR2
ex_have_inst  input  1  valid instruction in EX
ex_wR  input  5  EX destination register
ex_rf_we  input  1  EX writes the register file
ex_is_load  input  1  EX instruction is a load
ex_branch_taken  input  1  EX resolved a taken branch or jump
mem_have_inst  input  1  valid instruction in MEM
mem_wR  input  5  MEM destination register
mem_rf_we  input  1  MEM writes the register file
wb_have_inst  input  1  valid instruction in WB
wb_wR  input  5  WB destination register
wb_rf_we  input  1  WB writes the register file
cnt_clr  input  1  synchronous clear of all counters
pipeline_stop  output  1  hold PC, IF/ID and ID/EX payload
id_ex_hazard  output  1  insert a bubble into EX
if_id_flush  output  1  invalidate IF/ID
fwd_sel1  output  2  rD1 source: 0 = RF, 1 = EX, 2 = MEM, 3 = WB
fwd_sel2  output  2  rD2 source, same encoding as fwd_sel1
stall_cnt  output  CNT_W  load-use/RAW stall cycles
flush_cnt  output  CNT_W  flush events
fwd_cnt  output  CNT_W  cycles in which any fwd_sel is nonzero

Behaviour:
- Match definition: a stage X matches rRn when X_have_inst && X_rf_we && X_wR == rRn && rRn != 0 && id_ren && id_have_inst. Register x0 never matches.
- Forwarding (FWD_EN = 1), combinational, priority EX > MEM > WB:
  - EX match with ex_is_load = 0 -> sel 1.
  - else MEM match -> sel 2.
  - else WB match -> sel 3.
  - else 0.
- Load-use, FWD_EN = 1: EX match with ex_is_load = 1 on either operand.
- RAW, FWD_EN = 0: any EX or MEM match on either operand is a RAW stall. fwd_sel is forced to 0 except for a WB match, which selects 3 (write-through).
- FSM states: RUN, LU_STALL.
  - RUN -> LU_STALL on a load-use stall with no ex_branch_taken.
  - LU_STALL -> RUN unconditionally after one cycle; the load is then in MEM and forwards via sel 2.
  - RAW stalls with FWD_EN = 0 stay in RUN and repeat each cycle until no EX/MEM match remains.
- Outputs, combinational on current inputs, in priority order:
  - ex_branch_taken = 1: if_id_flush = 1, id_ex_hazard = 1, pipeline_stop = 0. A flush overrides any stall in the same cycle; the FSM stays in or returns to RUN.
  - Load-use or RAW stall: pipeline_stop = 1, id_ex_hazard = 1, if_id_flush = 0.
  - Otherwise all three are 0.
- LU_STALL masks load-use detection for that cycle. A back-to-back load-use from the next instruction re-enters LU_STALL only after one RUN cycle.
- Counters, registered, saturating at all-ones, never wrapping:
  - stall_cnt +1 per stall cycle.
  - flush_cnt +1 per cycle with ex_branch_taken.
  - fwd_cnt +1 per cycle with fwd_sel1 != 0 or fwd_sel2 != 0 while no stall or flush is active.
  - cnt_clr has priority over increment: cleared value is 0 on the next edge.
- Reset (rst_n = 0 at a rising edge):
  - state = RUN; all counters = 0.
  - While rst_n is low, outputs are forced: id_ex_hazard = 1, pipeline_stop = 0, if_id_flush = 1, fwd_sel = 0.
  - Reset during LU_STALL aborts the stall; the next cycle is RUN.
- Latency: control and forwarding outputs are 0-cycle (same cycle as inputs). Counters update 1 cycle later.

Decomposition:
- Shared package core_pkg: FWD_RF / FWD_EX / FWD_MEM / FWD_WB 2-bit constants; hazard FSM state enum (RUN, LU_STALL).
- One sub-module, sat_counter (CNT_W, inc, clr), instantiated three times.
- Match and priority logic stays inline.

Test Plan:
- Forwarding chain: add x5 in EX, id_rR1 = 5, id_re1 = 1 -> fwd_sel1 = 1, no stall. Same add in MEM only -> 2. In WB only -> 3. EX and MEM both write x5 -> 1.
- Load-use: lw x6 in EX, ID reads x6 on rR2 -> pipeline_stop = 1 and id_ex_hazard = 1 for exactly 1 cycle. Next cycle fwd_sel2 = 2, stall_cnt = 1.
- Branch beats stall: load-use condition plus ex_branch_taken = 1 in the same cycle -> if_id_flush = 1, id_ex_hazard = 1, pipeline_stop = 0, FSM stays in RUN, flush_cnt +1, stall_cnt unchanged.
- x0 and invalid stages: ex_wR = 0 with id_rR1 = 0 -> fwd_sel1 = 0, no stall. A matching stage with have_inst = 0 -> no match.
- FWD_EN = 0: add x7 in EX, ID reads x7 -> stalls 2 consecutive cycles (EX, then MEM). Third cycle fwd_sel = 3, no stall.
- Counters: force a stall every cycle with CNT_W = 4 -> stall_cnt saturates at 15. Assert cnt_clr -> 0 next cycle. rst_n low during LU_STALL -> state RUN, all counters 0, id_ex_hazard = 1 while reset is held.
